// File: rtl/if_stage_mo_pkg.sv
// Shared types and codes for the multi-outstanding instruction-fetch stage.
package if_stage_mo_pkg;

    // Exception codes handed to ID alongside each fetched entry.
    typedef enum logic [2:0] {
        FS_EXC_NONE = 3'd0,
        FS_EXC_ADEF = 3'd1,
        FS_EXC_TLBR = 3'd2,
        FS_EXC_PIF  = 3'd3,
        FS_EXC_PPI  = 3'd4
    } fs_exc_e;

    // Exception codes reported by the address translator.
    typedef enum logic [1:0] {
        TR_EXC_NONE = 2'd0,
        TR_EXC_TLBR = 2'd1,
        TR_EXC_PIF  = 2'd2,
        TR_EXC_PPI  = 2'd3
    } tr_exc_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        fs_exc_e     exc;
        logic        done;
    } fq_slot_t;

    localparam int FQ_SLOT_W = $bits(fq_slot_t);

    function automatic fs_exc_e tr_to_fs_exc(input tr_exc_e tr);
        fs_exc_e code;
        case (tr)
            TR_EXC_TLBR: code = FS_EXC_TLBR;
            TR_EXC_PIF:  code = FS_EXC_PIF;
            TR_EXC_PPI:  code = FS_EXC_PPI;
            default:     code = FS_EXC_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/if_stage_mo_fetch_queue.sv
// In-order fetch queue: slots are allocated at issue, filled in response order
// and popped by ID once done.
module if_stage_mo_fetch_queue
    import if_stage_mo_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
)(
    input  logic          clk,
    input  logic          reset,
    input  logic          flush_i,
    input  logic          alloc_i,
    input  fq_slot_t      alloc_slot_i,
    input  logic          fill_i,
    input  logic [31:0]   fill_inst_i,
    input  logic          pop_i,
    output fq_slot_t      head_o,
    output logic [CW-1:0] count_o
);

    logic [PW-1:0] alloc_q, alloc_d;
    logic [PW-1:0] fill_q, fill_d;
    logic [PW-1:0] head_q, head_d;
    logic [CW-1:0] count_q, count_d;
    logic          alloc_we;
    logic          fill_we;
    fq_slot_t      slot_view [DEPTH];

    assign alloc_we = alloc_i & ~flush_i;
    assign fill_we  = fill_i & ~flush_i;

    always_comb begin
        alloc_d = alloc_q;
        fill_d  = fill_q;
        head_d  = head_q;
        count_d = count_q;
        if (flush_i) begin
            alloc_d = '0;
            fill_d  = '0;
            head_d  = '0;
            count_d = '0;
        end else begin
            if (alloc_i) begin
                alloc_d = alloc_q + 1'b1;
            end
            // A slot born done (fault) is stepped over only when nothing is pending ahead of it.
            if (fill_i) begin
                fill_d = fill_q + 1'b1;
            end else if (alloc_i && alloc_slot_i.done && (fill_q == alloc_q)) begin
                fill_d = fill_q + 1'b1;
            end
            if (pop_i) begin
                head_d = head_q + 1'b1;
            end
            count_d = count_q + CW'(alloc_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alloc_q <= '0;
            fill_q  <= '0;
            head_q  <= '0;
            count_q <= '0;
        end else begin
            alloc_q <= alloc_d;
            fill_q  <= fill_d;
            head_q  <= head_d;
            count_q <= count_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            fq_slot_t entry_q;
            always_ff @(posedge clk) begin
                if (alloc_we && (alloc_q == PW'(gi))) begin
                    entry_q <= alloc_slot_i;
                end else if (fill_we && (fill_q == PW'(gi))) begin
                    entry_q.inst <= fill_inst_i;
                    entry_q.done <= 1'b1;
                end
            end
            assign slot_view[gi] = entry_q;
        end
    endgenerate

    assign head_o  = slot_view[head_q];
    assign count_o = count_q;

endmodule

// File: rtl/if_stage_mo.sv
// Instruction-fetch stage with several outstanding bus requests, a fetch queue
// toward ID, and redirect handling that discards stale in-flight responses.
module if_stage_mo
    import if_stage_mo_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h1c000000,
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          QUEUE_DEPTH     = 4
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        fetch_stall,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic [31:0] tr_va,
    input  logic [31:0] tr_pa,
    input  logic [1:0]  tr_exc,
    output logic        fs_to_ds_valid,
    input  logic        ds_allowin,
    output logic [31:0] fs_to_ds_pc,
    output logic [31:0] fs_to_ds_inst,
    output logic [2:0]  fs_to_ds_exc
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0] Q_FULL  = CW'(QUEUE_DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [OW-1:0] out_cnt_q, out_cnt_d;
    logic [OW-1:0] discard_cnt_q, discard_cnt_d;
    logic          fault_hold_q, fault_hold_d;

    logic          can_issue;
    logic          adef;
    logic          fault;
    fs_exc_e       fault_exc;
    logic          accept;
    logic          fault_alloc;
    logic          rsp_valid;
    logic          rsp_fill;
    logic          pop;
    fq_slot_t      alloc_slot;
    fq_slot_t      head;
    logic [CW-1:0] q_count;

    assign tr_va     = fetch_pc_q;
    assign inst_addr = tr_pa;

    // Misalignment outranks any translator fault.
    assign adef      = |fetch_pc_q[1:0];
    assign fault     = adef | (tr_exc != TR_EXC_NONE);
    assign fault_exc = adef ? FS_EXC_ADEF : tr_to_fs_exc(tr_exc_e'(tr_exc));

    assign can_issue   = ~reset & ~redirect_valid & ~fetch_stall & ~fault_hold_q & (q_count < Q_FULL);
    assign inst_req    = can_issue & ~fault & (out_cnt_q < OUT_MAX);
    assign accept      = inst_req & inst_addr_ok;
    assign fault_alloc = can_issue & fault;

    // A response with nothing outstanding is a bus protocol error and is ignored.
    assign rsp_valid = inst_data_ok & (out_cnt_q != '0);
    assign rsp_fill  = rsp_valid & ~redirect_valid & (discard_cnt_q == '0);

    assign fs_to_ds_valid = (q_count != '0) & head.done & ~redirect_valid;
    assign pop            = fs_to_ds_valid & ds_allowin;

    always_comb begin
        alloc_slot      = '0;
        alloc_slot.pc   = fetch_pc_q;
        alloc_slot.inst = '0;
        alloc_slot.exc  = fault_alloc ? fault_exc : FS_EXC_NONE;
        alloc_slot.done = fault_alloc;
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        out_cnt_d     = out_cnt_q + OW'(accept) - OW'(rsp_valid);
        discard_cnt_d = discard_cnt_q;
        fault_hold_d  = fault_hold_q;
        if (redirect_valid) begin
            // Every response still owed after this cycle belongs to the old stream.
            fetch_pc_d    = redirect_pc;
            fault_hold_d  = 1'b0;
            discard_cnt_d = out_cnt_q - OW'(rsp_valid);
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (fault_alloc) begin
                fault_hold_d = 1'b1;
            end
            if (rsp_valid && (discard_cnt_q != '0)) begin
                discard_cnt_d = discard_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            out_cnt_q     <= '0;
            discard_cnt_q <= '0;
            fault_hold_q  <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            out_cnt_q     <= out_cnt_d;
            discard_cnt_q <= discard_cnt_d;
            fault_hold_q  <= fault_hold_d;
        end
    end

    if_stage_mo_fetch_queue #(
        .DEPTH(QUEUE_DEPTH)
    ) u_fetch_queue (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (redirect_valid),
        .alloc_i     (accept | fault_alloc),
        .alloc_slot_i(alloc_slot),
        .fill_i      (rsp_fill),
        .fill_inst_i (inst_rdata),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (q_count)
    );

    assign fs_to_ds_pc   = head.pc;
    assign fs_to_ds_inst = head.inst;
    assign fs_to_ds_exc  = head.exc;

    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (reset)
        !(inst_data_ok && (out_cnt_q == '0)));

endmodule

// File: tb/tb_if_stage_mo.sv
// Directed and randomized bench for if_stage_mo against a stream-level model
// of the fetch address sequence and a simple in-order bus responder.
module tb_if_stage_mo;

    localparam logic [31:0] RESET_PC = 32'h1c000000;
    localparam int          MAX_OUT  = 2;
    localparam int          QD       = 4;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_stall;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic [31:0] tr_va;
    logic [31:0] tr_pa;
    logic [1:0]  tr_exc;
    logic        fs_to_ds_valid;
    logic        ds_allowin;
    logic [31:0] fs_to_ds_pc;
    logic [31:0] fs_to_ds_inst;
    logic [2:0]  fs_to_ds_exc;

    int vectors     = 0;
    int miscompares = 0;

    // Stimulus knobs
    int aok_pct   = 100;
    int dok_pct   = 100;
    int allow_pct = 100;
    int stall_pct = 0;
    int dly_min   = 1;
    int dly_max   = 1;
    bit force_dok = 0;

    // Reference model state
    logic [31:0] issue_pc;
    logic [31:0] exp_pc;
    bit          exp_halted;
    int          outstanding;
    int          max_out;
    int          accepts;
    int          pops;
    int          fault_pops;
    logic [2:0]  last_exc;
    int          cyc;
    logic [31:0] pend_addr [$];
    int          pend_due  [$];

    function automatic logic [31:0] xlate(input logic [31:0] va);
        return {3'b000, va[28:0]};
    endfunction

    function automatic logic [1:0] tr_code(input logic [31:0] va);
        if (va[31:12] == 20'h1c0ff) return (va[9:8] == 2'd0) ? 2'd2 : va[9:8];
        return 2'd0;
    endfunction

    function automatic logic [2:0] ref_exc(input logic [31:0] pc);
        if (pc[1:0] != 2'd0) return 3'd1;
        if (tr_code(pc) != 2'd0) return 3'(tr_code(pc)) + 3'd1;
        return 3'd0;
    endfunction

    function automatic logic [31:0] mem(input logic [31:0] pa);
        return (pa * 32'h9e3779b1) ^ 32'h5a5a1234;
    endfunction

    assign tr_pa  = xlate(tr_va);
    assign tr_exc = tr_code(tr_va);

    if_stage_mo #(
        .RESET_PC       (RESET_PC),
        .MAX_OUTSTANDING(MAX_OUT),
        .QUEUE_DEPTH    (QD)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .fetch_stall   (fetch_stall),
        .inst_req      (inst_req),
        .inst_addr     (inst_addr),
        .inst_addr_ok  (inst_addr_ok),
        .inst_data_ok  (inst_data_ok),
        .inst_rdata    (inst_rdata),
        .tr_va         (tr_va),
        .tr_pa         (tr_pa),
        .tr_exc        (tr_exc),
        .fs_to_ds_valid(fs_to_ds_valid),
        .ds_allowin    (ds_allowin),
        .fs_to_ds_pc   (fs_to_ds_pc),
        .fs_to_ds_inst (fs_to_ds_inst),
        .fs_to_ds_exc  (fs_to_ds_exc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit redir, input logic [31:0] rpc);
        bit         dok;
        bit         acc;
        logic [2:0] e;
        @(negedge clk);
        redirect_valid = redir;
        redirect_pc    = rpc;
        fetch_stall    = ($urandom_range(99) < stall_pct);
        ds_allowin     = ($urandom_range(99) < allow_pct);
        inst_addr_ok   = ($urandom_range(99) < aok_pct);
        dok = (pend_addr.size() > 0) &&
              (force_dok || ((pend_due[0] <= cyc) && ($urandom_range(99) < dok_pct)));
        inst_data_ok = dok;
        inst_rdata   = dok ? mem(pend_addr[0]) : $urandom();
        #1;
        chk("req_over_limit", 32'(inst_req && (outstanding >= MAX_OUT)), 32'd0);
        if (redir) chk("valid_in_redirect", 32'(fs_to_ds_valid), 32'd0);
        if (ref_exc(issue_pc) != 3'd0) begin
            chk("req_at_fault_pc", 32'(inst_req), 32'd0);
        end else if (inst_req) begin
            chk("req_va", tr_va, issue_pc);
            chk("req_pa", inst_addr, xlate(issue_pc));
        end
        if (!redir) begin
            if (exp_halted) begin
                chk("valid_after_fault", 32'(fs_to_ds_valid), 32'd0);
            end else if (fs_to_ds_valid && ds_allowin) begin
                e = ref_exc(exp_pc);
                chk("pop_pc", fs_to_ds_pc, exp_pc);
                chk("pop_exc", 32'(fs_to_ds_exc), 32'(e));
                chk("pop_inst", fs_to_ds_inst, (e != 3'd0) ? 32'd0 : mem(xlate(exp_pc)));
                $display("pop pc=%08h inst=%08h exc=%0d", fs_to_ds_pc, fs_to_ds_inst, fs_to_ds_exc);
                last_exc = e;
                pops++;
                if (e != 3'd0) begin
                    exp_halted = 1;
                    fault_pops++;
                end else begin
                    exp_pc = exp_pc + 32'd4;
                end
            end
        end
        acc = inst_req && inst_addr_ok;
        if (acc) begin
            pend_addr.push_back(inst_addr);
            pend_due.push_back(cyc + $urandom_range(dly_max, dly_min));
            outstanding++;
            accepts++;
            issue_pc = issue_pc + 32'd4;
        end
        if (dok) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
            outstanding--;
        end
        if (outstanding > max_out) max_out = outstanding;
        if (redir) begin
            issue_pc   = rpc;
            exp_pc     = rpc;
            exp_halted = 0;
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'd0);
    endtask

    task automatic wait_outstanding(input string tag, input int target);
        int k;
        k = 0;
        while ((outstanding != target) && (k < 20)) begin
            cycle(1'b0, 32'd0);
            k++;
        end
        chk(tag, 32'(outstanding), 32'(target));
    endtask

    initial begin
        int          a0;
        int          p0;
        int          f0;
        logic [31:0] t;
        logic [31:0] fpc [3];
        logic [2:0]  fexc [3];

        issue_pc    = RESET_PC;
        exp_pc      = RESET_PC;
        exp_halted  = 0;
        outstanding = 0;
        max_out     = 0;
        accepts     = 0;
        pops        = 0;
        fault_pops  = 0;
        last_exc    = 3'd0;
        cyc         = 0;

        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        fetch_stall    = 1'b0;
        inst_addr_ok   = 1'b0;
        inst_data_ok   = 1'b0;
        inst_rdata     = 32'd0;
        ds_allowin     = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_req", 32'(inst_req), 32'd0);
        chk("reset_valid", 32'(fs_to_ds_valid), 32'd0);
        reset = 1'b0;
        #1;
        chk("reset_pc", tr_va, RESET_PC);
        chk("first_req", 32'(inst_req), 32'd1);
        chk("first_addr", inst_addr, 32'h1c000000);
        chk("post_reset_valid", 32'(fs_to_ds_valid), 32'd0);

        // Streaming fetch with single-cycle responses
        run(20);
        chk("stream_pops", 32'(pops >= 8), 32'd1);

        // Slow responses: never more than two outstanding
        dly_min = 4; dly_max = 4; max_out = 0;
        run(16);
        chk("max_outstanding", 32'(max_out), 32'(MAX_OUT));

        // Redirect with two responses in flight
        dly_min = 6; dly_max = 6;
        wait_outstanding("reach_two_c", 2);
        dly_min = 1; dly_max = 1;
        cycle(1'b1, 32'h1c000100);
        p0 = pops;
        run(15);
        chk("redirect_new_pops", 32'(pops > p0), 32'd1);
        chk("discard_drained", 32'(dut.discard_cnt_q), 32'd0);

        // Misaligned redirect target
        f0 = fault_pops;
        cycle(1'b1, 32'h1c000102);
        run(6);
        chk("adef_pops", 32'(fault_pops - f0), 32'd1);
        chk("adef_exc", 32'(last_exc), 32'd1);
        chk("adef_halt_va", tr_va, 32'h1c000102);

        // Translator faults on aligned addresses
        fpc[0] = 32'h1c0ff000; fexc[0] = 3'd3;
        fpc[1] = 32'h1c0ff100; fexc[1] = 3'd2;
        fpc[2] = 32'h1c0ff300; fexc[2] = 3'd4;
        for (int i = 0; i < 3; i++) begin
            f0 = fault_pops;
            cycle(1'b1, fpc[i]);
            run(6);
            chk("tr_fault_pops", 32'(fault_pops - f0), 32'd1);
            chk("tr_fault_exc", 32'(last_exc), 32'(fexc[i]));
        end

        // ID back-pressure fills the queue exactly
        allow_pct = 0;
        cycle(1'b1, 32'h1c000200);
        a0 = accepts;
        run(10);
        #1;
        chk("bp_accepts", 32'(accepts - a0), 32'(QD));
        chk("bp_req_low", 32'(inst_req), 32'd0);
        chk("bp_valid", 32'(fs_to_ds_valid), 32'd1);
        allow_pct = 100;
        p0 = pops;
        run(8);
        chk("bp_drain", 32'(pops - p0 >= QD), 32'd1);

        // Redirect coinciding with a response while two are in flight
        dly_min = 8; dly_max = 8;
        cycle(1'b1, 32'h1c000280);
        wait_outstanding("reach_two_f", 2);
        force_dok = 1;
        cycle(1'b1, 32'h1c000300);
        force_dok = 0;
        #1;
        chk("discard_one", 32'(dut.discard_cnt_q), 32'd1);
        dly_min = 1; dly_max = 1;
        p0 = pops;
        run(20);
        chk("after_merge_pops", 32'(pops > p0), 32'd1);

        // Randomized traffic with occasional redirects
        aok_pct = 70; dok_pct = 70; allow_pct = 75; stall_pct = 10;
        dly_min = 1; dly_max = 5;
        p0 = pops;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(99) < 3) begin
                case ($urandom_range(7))
                    0: t = 32'h1c0ff000 | (32'($urandom_range(3)) << 8);
                    1: t = (32'h1c000000 + 32'($urandom_range(4095)) * 32'd4) | 32'($urandom_range(3, 1));
                    2: t = 32'h1c0fefe0;
                    default: t = 32'h1c000000 + 32'($urandom_range(16383)) * 32'd4;
                endcase
                cycle(1'b1, t);
            end else begin
                cycle(1'b0, 32'd0);
            end
        end
        chk("random_progress", 32'(pops - p0 > 50), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
